bcd_seg7_display: RTL
=====================

// Module: bcd_seg7_display
// PURPOSE
//  - Downstream stage of the two-operand summator. Takes a binary result word and converts it to
//    decimal with an iterative shift-add-3 (double-dabble) engine.
//  - Drives DIGITS active-low 7-segment displays (HEX2..HEX7 on the board).
//  - Output segments are registered and hold the last completed value until the next conversion finishes.
// PARAMETERS
//  WIDTH   17  bit width of the binary input word
//  DIGITS  6   number of decimal digits / 7-seg displays driven
// PORTS
//  clk        in   1           system clock (CLOCK_50)
//  rst_n      in   1           asynchronous reset, active-low
//  in_valid   in   1           input word present this cycle
//  in_data    in   WIDTH       unsigned binary value to display
//  in_ready   out  1           block can accept a word (IDLE)
//  out_valid  out  1           one-cycle pulse: hex/overflow just updated
//  overflow   out  1           last value >= 10**DIGITS
//  hex        out  7*DIGITS    segments, gfedcba, active-low; digit 0 (units) in [6:0]
// BEHAVIOUR
//  - One clock domain (clk). rst_n is asynchronous and active-low.
//  - Reset values:
//      - hex = all 1s (all segments dark), in_ready = 1, out_valid = 0, overflow = 0, FSM = IDLE.
//  - FSM IDLE -> SHIFT -> LOAD -> IDLE:
//      - IDLE: in_ready = 1. On in_valid, latch in_data into the shift register, clear the BCD register
//        (4*DIGITS bits) and the overflow tracker, load bit counter = WIDTH, go to SHIFT.
//      - SHIFT: each cycle, first add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1.
//        Decrement the counter; at 0 go to LOAD. Exactly WIDTH cycles in SHIFT.
//      - LOAD: decode the nibbles to segments, register hex and overflow, pulse out_valid. Return to IDLE.
//  - Latency: in_valid accepted at edge N -> hex valid and out_valid high at edge N+WIDTH+1.
//  - in_ready is 0 in SHIFT and LOAD. in_valid there is ignored: no queueing, no corruption.
//  - Overflow: a 1 shifted out of the top nibble sets a sticky flag for that conversion.
//      - Flag set: every digit shows "-" (7'b0111111) and overflow = 1.
//      - Flag clear: overflow = 0.
//  - Nibble values 10..15 cannot occur. The decoder maps them to blank as a safeguard.
//  - Reset mid-conversion: outputs return to reset values immediately and the partial result is discarded.
//  - in_valid asserted in the same cycle rst_n rises: not accepted. The first accept is on the next edge.
//  - Arithmetic: in_data is unsigned. The nibble adjust is 4-bit and does not carry between nibbles.
// CONFIGURATION
//  - Macro BCD_SEG7_BLANK_LZ_EN:
//      - Defined: leading zero digits are blanked (7'b1111111). Digit 0 always shows, so value 0 -> "     0".
//        Applied in LOAD. No effect on overflow dashes.
//      - Undefined: every digit is always shown, so value 0 -> "000000".
// STRUCTURE
//  - Shared header seg7_pkg.vh holds:
//      - the segment code constants for 0..9, dash and blank (active-low, gfedcba);
//      - the FSM state encodings IDLE = 2'd0, SHIFT = 2'd1, LOAD = 2'd2.
//  - One sub-module, seg7_decoder: combinational 4-bit nibble -> 7-bit code.
//    DIGITS instances are created with a generate loop. The FSM, counter and datapath stay in this module.
// TESTING (WIDTH=17, DIGITS=6 unless stated)
//  - Reset: assert rst_n=0 mid-SHIFT -> hex=7'h7F on every digit, in_ready=1, out_valid=0 at once.
//    After release, the next conversion is correct.
//  - in_data=0:
//      - without macro -> all six digits 7'b1000000 ("000000");
//      - with BCD_SEG7_BLANK_LZ_EN -> digits 5..1 blank, digit 0 = 7'b1000000.
//  - in_data=131071 -> digits 5..0 = 1,3,1,0,7,1; out_valid pulses exactly 18 cycles after accept;
//    overflow = 0.
//  - in_data=9 then 10 in back-to-back accepts:
//      - in_valid held high during busy is ignored;
//      - two out_valid pulses, 18 cycles apart minimum;
//      - displays "000009" then "000010".
//  - DIGITS=4 instance, in_data=10000 -> overflow=1, all four digits 7'b0111111.
//    A following in_data=9999 -> overflow=0, display "9999".
//  - Random sweep: 1000 values in 0..131071 checked against a $sformat("%06d") reference model.

Source files
------------

// File: rtl/bcd_seg7_display_pkg.sv
// Shared constants for the BCD to 7-segment display: segment codes (active-low, gfedcba)
// and FSM state encodings.
package bcd_seg7_display_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StLoad  = 2'd2
    } state_e;

    localparam logic [6:0] Seg0     = 7'b1000000;
    localparam logic [6:0] Seg1     = 7'b1111001;
    localparam logic [6:0] Seg2     = 7'b0100100;
    localparam logic [6:0] Seg3     = 7'b0110000;
    localparam logic [6:0] Seg4     = 7'b0011001;
    localparam logic [6:0] Seg5     = 7'b0010010;
    localparam logic [6:0] Seg6     = 7'b0000010;
    localparam logic [6:0] Seg7     = 7'b1111000;
    localparam logic [6:0] Seg8     = 7'b0000000;
    localparam logic [6:0] Seg9     = 7'b0010000;
    localparam logic [6:0] SegDash  = 7'b0111111;
    localparam logic [6:0] SegBlank = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD nibble to active-low 7-segment code; values 10..15 decode to blank.
module seg7_decoder
    import bcd_seg7_display_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SegBlank;
        case (nibble_i)
            4'd0:    seg_o = Seg0;
            4'd1:    seg_o = Seg1;
            4'd2:    seg_o = Seg2;
            4'd3:    seg_o = Seg3;
            4'd4:    seg_o = Seg4;
            4'd5:    seg_o = Seg5;
            4'd6:    seg_o = Seg6;
            4'd7:    seg_o = Seg7;
            4'd8:    seg_o = Seg8;
            4'd9:    seg_o = Seg9;
            default: seg_o = SegBlank;
        endcase
    end

endmodule

// File: rtl/bcd_seg7_display.sv
// Binary to decimal (double-dabble) converter driving DIGITS active-low 7-segment displays.
// Optional leading-zero blanking when BCD_SEG7_BLANK_LZ_EN is defined.
module bcd_seg7_display
    import bcd_seg7_display_pkg::*;
#(
    parameter int unsigned WIDTH  = 17,
    parameter int unsigned DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   hex
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [BcdW-1:0]     bcd_q, bcd_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                ovf_trk_q, ovf_trk_d;
    logic [7*DIGITS-1:0] hex_q, hex_d;
    logic                ovf_q, ovf_d;
    logic                out_valid_q, out_valid_d;

    logic [BcdW-1:0]     bcd_adj;
    logic [7*DIGITS-1:0] hex_load;
    logic [6:0]          seg_raw [DIGITS];

    for (genvar g = 0; g < int'(DIGITS); g++) begin : gen_dec
        seg7_decoder u_dec (
            .nibble_i (bcd_q[4*g +: 4]),
            .seg_o    (seg_raw[g])
        );
    end

    // Per-nibble add-3; 4-bit wrap, no carry into the neighbour.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
`ifdef BCD_SEG7_BLANK_LZ_EN
        logic lead;
        lead = 1'b1;
`endif
        hex_load = '1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (ovf_trk_q) begin
                hex_load[7*i +: 7] = SegDash;
            end else begin
`ifdef BCD_SEG7_BLANK_LZ_EN
                if (lead && (i != 0) && (bcd_q[4*i +: 4] == 4'd0)) begin
                    hex_load[7*i +: 7] = SegBlank;
                end else begin
                    hex_load[7*i +: 7] = seg_raw[i];
                    lead = 1'b0;
                end
`else
                hex_load[7*i +: 7] = seg_raw[i];
`endif
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        ovf_trk_d   = ovf_trk_q;
        hex_d       = hex_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    bin_d     = in_data;
                    bcd_d     = '0;
                    ovf_trk_d = 1'b0;
                    cnt_d     = CntW'(WIDTH);
                    state_d   = StShift;
                end
            end
            StShift: begin
                {bcd_d, bin_d} = {bcd_adj[BcdW-2:0], bin_q, 1'b0};
                // Anything leaving the top nibble means the value needs more digits.
                ovf_trk_d      = ovf_trk_q | bcd_adj[BcdW-1];
                cnt_d          = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                hex_d       = hex_load;
                ovf_d       = ovf_trk_q;
                out_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            ovf_trk_q   <= 1'b0;
            hex_q       <= '1;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            ovf_trk_q   <= ovf_trk_d;
            hex_q       <= hex_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign overflow  = ovf_q;
    assign hex       = hex_q;

endmodule
